serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits, legal range 1..64.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request to begin an addition, sampled on rising edge.
REQ-005 SHALL have port: a  input  WIDTH  operand A, sampled only with an accepted start.
REQ-006 SHALL have port: b  input  WIDTH  operand B, sampled only with an accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in, sampled only with an accepted start.
REQ-008 SHALL have port: sub  input  1  subtract request, sampled with an accepted start; function set by REQ-030/031.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse marking a completed result.
REQ-011 SHALL have port: sum  output  WIDTH  result, held until the next accepted start.
REQ-012 SHALL have port: cout  output  1  carry out of the MSB.
REQ-013 SHALL have port: overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Function
REQ-014 SHALL implement a two-state FSM, IDLE and RUN, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-015 SHALL accept start only in IDLE; accepted start loads A and B shift registers and the carry flop, clears the counter, enters RUN.
REQ-016 SHALL ignore start while in RUN; operands and result are unaffected.
REQ-017 SHALL process one bit per clock in RUN, LSB first, using a single 1-bit full adder (sum = a^b^c, carry = ab|ac|bc) and registered carry.
REQ-018 SHALL shift each sum bit into the MSB of the sum register, shifting right, so sum[0] holds bit 0 after WIDTH bits.
REQ-019 SHALL, on the edge processing bit WIDTH-1, return to IDLE, drive busy low, pulse done high for exactly one cycle, and update cout and overflow.
REQ-020 SHALL have latency: start accepted at edge E0 -> done high in the cycle after edge E(WIDTH); busy high for exactly WIDTH cycles.
REQ-021 SHALL accept a start asserted during the done cycle (FSM is in IDLE), giving back-to-back operations with no idle gap.
REQ-022 SHALL keep sum, cout, overflow stable from done until the edge that completes the next operation; intermediate shift contents are not visible on sum (separate shift and result registers).
REQ-023 SHALL support WIDTH=1: busy one cycle, overflow = carry-in XOR carry-out of the single bit.
REQ-024 SHALL compute sum as (A + B' + c0) mod 2^WIDTH, where B' and c0 are given by REQ-030/031.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force IDLE, counter 0, busy 0, done 0, sum 0, cout 0, overflow 0, shift registers 0.
REQ-026 SHALL abort any operation in progress when reset is asserted mid-RUN; no done pulse is produced for it.
REQ-027 SHALL ignore start on the first rising edge coinciding with rst_n still low; first acceptance is on an edge with rst_n high.

Configuration
REQ-028 SHALL use macro SERIAL_ADDER_SUB_EN to compile the subtract mode in or out.
REQ-029 SHALL behave identically for sub=0 whether or not the macro is defined.
REQ-030 SHALL, with SERIAL_ADDER_SUB_EN defined and sub=1 at start, use B' = ~b and c0 = 1 (cin ignored), giving A-B; cout=1 means no borrow.
REQ-031 SHALL, without SERIAL_ADDER_SUB_EN, ignore sub entirely: B' = b, c0 = cin.

Verification
REQ-032 SHALL verify: WIDTH=8, a=0xFF b=0x01 cin=0 start -> busy 8 cycles, done pulse, sum=0x00 cout=1 overflow=0.
REQ-033 SHALL verify: a=0x7F b=0x01 cin=0 -> sum=0x80 cout=0 overflow=1; a=0x80 b=0x80 cin=1 -> sum=0x01 cout=1 overflow=1.
REQ-034 SHALL verify (macro defined): a=0x05 b=0x07 sub=1 -> sum=0xFE cout=0 overflow=0; macro undefined, same stimulus, cin=0 -> sum=0x0C.
REQ-035 SHALL verify: start re-asserted mid-RUN with different operands -> ignored, first result unchanged; start in done cycle -> new op accepted, busy high next cycle.
REQ-036 SHALL verify: rst_n pulsed low at bit 4 of an op -> all outputs 0 immediately, no done; new start after release yields correct result.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first, result held between ops.
// Optional subtract mode compiled in with `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_sh_nx;
   logic [WIDTH-1:0] b_eff;
   logic             carry, c0;
   logic             bit_s, bit_c, last;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is A + ~B + 1; cin is deliberately ignored in that mode.
   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? 1'b1 : cin;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign b_eff      = b;
   assign c0         = cin;
`endif

   assign busy = (state == RUN);

   always_comb begin
      bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
      bit_c    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      s_sh_nx  = s_sh >> 1;
      s_sh_nx[WIDTH-1] = bit_s;
      last     = (cnt == CW'(WIDTH - 1));
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Shift registers are separate from the result so partial sums never reach sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         s_sh     <= '0;
         carry    <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b_eff;
                  carry <= c0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               s_sh  <= s_sh_nx;
               carry <= bit_c;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum      <= s_sh_nx;
                  cout     <= bit_c;
                  overflow <= carry ^ bit_c;
                  done     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
